// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side handshake bundle for mem_arbiter
//   icache : iREN, iaddr -> arbiter; iwait, iload <- arbiter
//   dcache : dREN, dWEN, daddr, dstore -> arbiter; dwait, dload <- arbiter
//   RAM    : ramREN, ramWEN, ramaddr, ramstore <- arbiter; ramload, ramstate -> arbiter
//   status : ramerr (sticky RAM error flag) <- arbiter
//   slave modport is the arbiter view, master is the caches+RAM view
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ramerr;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between icache and dcache word requests
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (cache requests/stalls, RAM enables/data, ramerr)
//   STARVE_MAX : consecutive dcache grants tolerated while iREN waits (1..15)
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] IGRANT = 2'd2;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  logic [1:0] state, state_n;
  logic [3:0] starve, starve_n;
  logic       ramerr_q;
  logic       d_req, done, force_i;
  assign d_req   = bus.dREN | bus.dWEN;
  assign done    = bus.ramstate == ACCESS;
  assign force_i = bus.iREN && (starve >= 4'(STARVE_MAX));
  always_comb begin
    state_n  = state;
    starve_n = starve;
    case (state)
      IDLE: state_n = (d_req && !force_i) ? DGRANT : bus.iREN ? IGRANT : IDLE;
      DGRANT: begin
        // starve counts dcache words served while icache kept asking
        if (done) begin
          state_n  = IDLE;
          starve_n = !bus.iREN ? 4'd0 : (starve == 4'hf) ? starve : starve + 4'd1;
        end else if (!d_req) state_n = IDLE;
      end
      IGRANT: begin
        if (done) begin
          state_n  = IDLE;
          starve_n = 4'd0;
        end else if (!bus.iREN) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // write wins over read when dcache raises both
  assign bus.ramREN   = (state == IGRANT) | ((state == DGRANT) & bus.dREN & ~bus.dWEN);
  assign bus.ramWEN   = (state == DGRANT) & bus.dWEN;
  assign bus.ramaddr  = (state == DGRANT) ? bus.daddr : (state == IGRANT) ? bus.iaddr : 32'd0;
  assign bus.ramstore = (state == DGRANT) ? bus.dstore : 32'd0;
  assign bus.iwait    = (state == IGRANT) ? !done : bus.iREN;
  assign bus.dwait    = (state == DGRANT) ? !done : d_req;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.ramerr   = ramerr_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      starve   <= 4'd0;
      ramerr_q <= 1'b0;
    end else begin
      state    <= state_n;
      starve   <= starve_n;
      ramerr_q <= ramerr_q | ((state != IDLE) && (bus.ramstate == ERROR));
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive dcache grants allowed while iREN is pending before icache is forced (range 1..15).
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 iREN  in  1  icache word read request.
REQ-005 iaddr  in  32  icache word address.
REQ-006 iwait  out  1  icache stall; 0 for exactly the completing cycle.
REQ-007 iload  out  32  icache read data.
REQ-008 dREN  in  1  dcache word read request.
REQ-009 dWEN  in  1  dcache word write request.
REQ-010 daddr  in  32  dcache word address.
REQ-011 dstore  in  32  dcache write data.
REQ-012 dwait  out  1  dcache stall; 0 for exactly the completing cycle.
REQ-013 dload  out  32  dcache read data.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (word done), 3 ERROR.
REQ-020 ramerr  out  1  sticky flag, set on any ERROR seen while granted.

Function
REQ-021 FSM SHALL have states IDLE, DGRANT, IGRANT plus a 4-bit saturating starve counter.
REQ-022 IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0; iwait=iREN; dwait=dREN|dWEN.
REQ-023 IDLE->DGRANT if (dREN|dWEN) and not (iREN and starve>=STARVE_MAX); else IDLE->IGRANT if iREN; else stay.
REQ-024 DGRANT: ramaddr=daddr, ramstore=dstore; dWEN has priority: ramWEN=dWEN, ramREN=dREN&~dWEN.
REQ-025 DGRANT: dwait=(ramstate!=ACCESS); iwait=iREN.
REQ-026 IGRANT: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0; iwait=(ramstate!=ACCESS); dwait=dREN|dWEN.
REQ-027 iload and dload SHALL both equal ramload combinationally in every state.
REQ-028 On ACCESS in DGRANT: next state IDLE; starve<=starve+1 (saturate at 15) if iREN, else 0.
REQ-029 On ACCESS in IGRANT: next state IDLE; starve<=0.
REQ-030 Granted requester deasserting all its enables before ACCESS: return to IDLE next cycle, starve unchanged.
REQ-031 BUSY/FREE/ERROR while granted: hold state and all RAM outputs; ERROR sets ramerr.
REQ-032 Minimum word latency 2 cycles: request at IDLE edge N, RAM enable from cycle N+1, earliest wait=0 in N+1.
REQ-033 A dcache two-word block transfer SHALL re-arbitrate between words (IDLE cycle between); no lock.
REQ-034 Never ramREN and ramWEN both 1; never both iwait=0 and dwait=0 in same cycle.

Reset
REQ-035 nRST low SHALL immediately force IDLE, starve=0, ramerr=0; outputs take IDLE values per REQ-022.
REQ-036 Reset mid-grant SHALL abandon the transfer; no completion (wait=0) is issued for it.

Verification
REQ-037 Lone iREN, iaddr=0x40, ramstate ACCESS one cycle after grant, ramload=0x8C010004 -> ramREN=1 ramaddr=0x40, iwait=0 one cycle, iload=0x8C010004.
REQ-038 dREN and iREN together from IDLE, STARVE_MAX=4 -> dcache served first; ramaddr=daddr; then icache on next arbitration if dcache drops.
REQ-039 dREN held continuously with iREN, STARVE_MAX=2 -> two dcache words complete, third grant goes to icache, starve returns to 0.
REQ-040 dWEN=dREN=1, daddr=0x3100, dstore=0xBAD1BAD1 -> ramWEN=1, ramREN=0, ramstore=0xBAD1BAD1.
REQ-041 ramstate=ERROR for 3 cycles during DGRANT then ACCESS -> dwait=1 during ERROR, outputs stable, ramerr=1 until reset.
REQ-042 nRST pulsed during IGRANT with ramstate BUSY -> IDLE, ramREN=0 at once, iwait=iREN, no spurious iwait=0.
